// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Per-frame ball physics and rally state machine. Once per VGA frame
//   (rising edge of vsync) the ball advances, bounces off the table walls
//   and the player's paddle, and a miss freezes the ball for a while before
//   it returns to the serve position.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | ball parked at the serve point, waiting for a serve press
//   PLAY  | ball moving; paddle hits counted in score
//   MISS  | ball frozen at the right wall for MISS_FRAMES frames
//
// Ports
//   clk          system/pixel clock (shared with the VGA timing generator)
//   reset        asynchronous, active-high
//   vsync        VGA vertical sync, same clock domain
//   serve        debounced serve button (level)
//   xpat, ypat   paddle centre from the paddle-tracking path
//   xball, yball ball centre towards the renderer
//   score        paddle hits in the current/last rally
//   state        00 IDLE, 01 PLAY, 10 MISS
module pong_ball_engine #(
  parameter int X_MIN       = 58,
  parameter int X_MAX       = 1222,
  parameter int Y_MIN       = 58,
  parameter int Y_MAX       = 732,
  parameter int RBALL       = 20,
  parameter int RPAT        = 60,
  parameter int X_SERVE     = 300,
  parameter int Y_SERVE     = 395,
  parameter int VX0         = 4,
  parameter int VY0         = 3,
  parameter int VX_MAX      = 12,
  parameter int MISS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        serve,
  input  logic [10:0] xpat,
  input  logic [10:0] ypat,
  output logic [10:0] xball,
  output logic [10:0] yball,
  output logic [7:0]  score,
  output logic [1:0]  state
);

  localparam int VW = $clog2(VX_MAX + 1);
  localparam int CW = $clog2(MISS_FRAMES);

  // Ball-centre limits and paddle reach as 12-bit signed values so that
  // the per-frame arithmetic can go below zero without wrapping.
  localparam logic signed [11:0] X_LO  = 12'(X_MIN + RBALL);
  localparam logic signed [11:0] X_HI  = 12'(X_MAX - RBALL);
  localparam logic signed [11:0] Y_LO  = 12'(Y_MIN + RBALL);
  localparam logic signed [11:0] Y_HI  = 12'(Y_MAX - RBALL);
  localparam logic signed [11:0] HIT_R = 12'(RBALL + RPAT);
  localparam logic signed [11:0] VY_S  = 12'(VY0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_MISS = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     x_q, x_d;
  logic [10:0]     y_q, y_d;
  logic [VW-1:0]   vx_q, vx_d;
  logic            dirx_q, dirx_d;   // 1 = moving right
  logic            diry_q, diry_d;   // 1 = moving down
  logic [7:0]      score_q, score_d;
  logic [CW-1:0]   miss_cnt_q, miss_cnt_d;
  logic            vsync_q;
  logic            serve_q;

  logic            tick;
  logic            serve_edge;

  logic signed [11:0] x_s, y_s, vx_s;
  logic signed [11:0] xpat_s, ypat_s;
  logic signed [11:0] nx, ny;
  logic signed [11:0] dx, dy, adx, ady;
  logic signed [11:0] hit_x;
  logic               hit;
  logic [7:0]         score_inc;
  logic [VW-1:0]      vx_inc;

  assign tick       = vsync & ~vsync_q;
  assign serve_edge = serve & ~serve_q;

  assign x_s    = $signed({1'b0, x_q});
  assign y_s    = $signed({1'b0, y_q});
  assign vx_s   = $signed({{(12 - VW){1'b0}}, vx_q});
  assign xpat_s = $signed({1'b0, xpat});
  assign ypat_s = $signed({1'b0, ypat});

  assign nx = dirx_q ? (x_s + vx_s) : (x_s - vx_s);
  assign ny = diry_q ? (y_s + VY_S) : (y_s - VY_S);

  // Paddle box test: candidate x against paddle x, current y against paddle y.
  assign dx  = nx - xpat_s;
  assign dy  = y_s - ypat_s;
  assign adx = (dx < 0) ? -dx : dx;
  assign ady = (dy < 0) ? -dy : dy;
  assign hit = dirx_q && (adx <= HIT_R) && (ady <= HIT_R);

  // Ball parks against the paddle face, never past the table edges.
  assign hit_x = xpat_s - HIT_R;

  assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  assign vx_inc    = (vx_q < VW'(VX_MAX)) ? vx_q + VW'(1) : vx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= 11'(X_SERVE);
      y_q        <= 11'(Y_SERVE);
      vx_q       <= VW'(VX0);
      dirx_q     <= 1'b1;
      diry_q     <= 1'b1;
      score_q    <= 8'd0;
      miss_cnt_q <= '0;
      vsync_q    <= 1'b0;
      serve_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vx_q       <= vx_d;
      dirx_q     <= dirx_d;
      diry_q     <= diry_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
      vsync_q    <= vsync;
      serve_q    <= serve;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    dirx_d     = dirx_q;
    diry_d     = diry_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      ST_IDLE: begin
        x_d = 11'(X_SERVE);
        y_d = 11'(Y_SERVE);
        // A tick coinciding with the serve only changes state; motion
        // starts on the following frame.
        if (serve_edge) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
          vx_d    = VW'(VX0);
          dirx_d  = 1'b1;
          diry_d  = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          if (!diry_q && (ny <= Y_LO)) begin
            y_d    = Y_LO[10:0];
            diry_d = 1'b1;
          end else if (diry_q && (ny >= Y_HI)) begin
            y_d    = Y_HI[10:0];
            diry_d = 1'b0;
          end else begin
            y_d = ny[10:0];
          end

          if (!dirx_q && (nx <= X_LO)) begin
            x_d    = X_LO[10:0];
            dirx_d = 1'b1;
          end else if (hit) begin
            if (hit_x < X_LO)      x_d = X_LO[10:0];
            else if (hit_x > X_HI) x_d = X_HI[10:0];
            else                   x_d = hit_x[10:0];
            dirx_d  = 1'b0;
            score_d = score_inc;
            // The paddle decides vertical direction, overriding a wall
            // bounce in the same frame.
            diry_d  = !(y_s < ypat_s);
            if (score_inc[1:0] == 2'b00) vx_d = vx_inc;
          end else if (dirx_q && (nx >= X_HI)) begin
            x_d        = X_HI[10:0];
            state_d    = ST_MISS;
            miss_cnt_d = '0;
          end else begin
            x_d = nx[10:0];
          end
        end
      end

      ST_MISS: begin
        // Counter holds frames already waited; the frame that finds it at
        // MISS_FRAMES-1 is the last frozen one.
        if (tick) begin
          if (miss_cnt_q == CW'(MISS_FRAMES - 1)) begin
            state_d = ST_IDLE;
            x_d     = 11'(X_SERVE);
            y_d     = 11'(Y_SERVE);
          end else begin
            miss_cnt_d = miss_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign xball = x_q;
  assign yball = y_q;
  assign score = score_q;
  assign state = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        serve = 1'b0;
  logic [10:0] xpat = 11'd1100;
  logic [10:0] ypat = 11'd1900;
  logic [10:0] xball, yball;
  logic [7:0]  score;
  logic [1:0]  state;

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .serve (serve),
    .xpat  (xpat),
    .ypat  (ypat),
    .xball (xball),
    .yball (yball),
    .score (score),
    .state (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: game rules in plain integers.
  int m_x, m_y, m_vx, m_score, m_mode, m_frozen;
  bit m_right, m_down;

  localparam int OP_RESET = 0, OP_TICK = 1, OP_SERVE = 2, OP_BOTH = 3;

  typedef struct {
    int op;
    int xp;
    int yp;
    int ex;
    int ey;
    int es;
    int est;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"}, int'(xball), m_x);
    check({tag, "_y"}, int'(yball), m_y);
    check({tag, "_score"}, int'(score), m_score);
    check({tag, "_state"}, int'(state), m_mode);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_x = 300; m_y = 395; m_vx = 4; m_score = 0; m_mode = 0; m_frozen = 0;
    m_right = 1; m_down = 1;
  endtask

  task automatic model_serve();
    if (m_mode == 0) begin
      m_mode = 1; m_score = 0; m_vx = 4; m_right = 1; m_down = 1;
    end
  endtask

  task automatic model_tick();
    int nx, ny, oy, xp, yp, px;
    xp = int'(xpat);
    yp = int'(ypat);
    if (m_mode == 1) begin
      oy = m_y;
      nx = m_right ? m_x + m_vx : m_x - m_vx;
      ny = m_down ? m_y + 3 : m_y - 3;
      if (!m_down && ny <= 78) begin m_y = 78; m_down = 1; end
      else if (m_down && ny >= 712) begin m_y = 712; m_down = 0; end
      else m_y = ny;
      if (!m_right && nx <= 78) begin
        m_x = 78; m_right = 1;
      end else if (m_right && iabs(nx - xp) <= 80 && iabs(oy - yp) <= 80) begin
        px = xp - 80;
        if (px < 78) px = 78;
        if (px > 1202) px = 1202;
        m_x = px;
        m_right = 0;
        if (m_score < 255) m_score++;
        m_down = !(oy < yp);
        if (m_score % 4 == 0 && m_vx < 12) m_vx++;
      end else if (m_right && nx >= 1202) begin
        m_x = 1202; m_mode = 2; m_frozen = 0;
      end else begin
        m_x = nx;
      end
    end else if (m_mode == 2) begin
      m_frozen++;
      if (m_frozen == 60) begin
        m_mode = 0; m_x = 300; m_y = 395;
      end
    end
  endtask

  task automatic do_tick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
    model_tick();
  endtask

  task automatic do_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk);
    @(negedge clk) serve = 1'b0;
    @(negedge clk);
    model_serve();
  endtask

  task automatic do_both();
    @(negedge clk) begin serve = 1'b1; vsync = 1'b1; end
    @(negedge clk);
    @(negedge clk) begin serve = 1'b0; vsync = 1'b0; end
    @(negedge clk);
    model_serve();
  endtask

  task automatic do_reset();
    @(negedge clk) begin reset = 1'b1; vsync = 1'b0; serve = 1'b0; end
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  vec_t vecs[$];

  initial begin
    int t, n;
    logic [10:0] hx, hy;
    logic [7:0]  hs;
    logic [1:0]  hst;

    model_reset();

    // Directed vectors with hand-computed expectations.
    vecs.push_back('{OP_RESET, 1100, 1900, 300, 395, 0, 0});
    vecs.push_back('{OP_TICK,  1100, 1900, 300, 395, 0, 0});
    vecs.push_back('{OP_SERVE, 1100, 1900, 300, 395, 0, 1});
    vecs.push_back('{OP_TICK,  1100, 1900, 304, 398, 0, 1});
    vecs.push_back('{OP_TICK,  1100, 1900, 308, 401, 0, 1});
    vecs.push_back('{OP_SERVE, 1100, 1900, 308, 401, 0, 1});
    vecs.push_back('{OP_TICK,  1100, 1900, 312, 404, 0, 1});
    vecs.push_back('{OP_RESET, 1100, 1900, 300, 395, 0, 0});
    vecs.push_back('{OP_BOTH,  1100, 1900, 300, 395, 0, 1});
    vecs.push_back('{OP_TICK,  1100, 1900, 304, 398, 0, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      xpat = 11'(vecs[i].xp);
      ypat = 11'(vecs[i].yp);
      case (vecs[i].op)
        OP_RESET: do_reset();
        OP_TICK:  do_tick();
        OP_SERVE: do_serve();
        default:  do_both();
      endcase
      check($sformatf("vec%0d_x", i), int'(xball), vecs[i].ex);
      check($sformatf("vec%0d_y", i), int'(yball), vecs[i].ey);
      check($sformatf("vec%0d_score", i), int'(score), vecs[i].es);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].est);
    end

    // Outputs hold steady between frames.
    hx = xball; hy = yball; hs = score; hst = state;
    repeat (7) @(negedge clk);
    check("hold_x", int'(xball), int'(hx));
    check("hold_y", int'(yball), int'(hy));
    check("hold_score", int'(score), int'(hs));
    check("hold_state", int'(state), int'(hst));

    // Bottom-wall bounce: y = 395 + 3k reaches 710 after 105 frames.
    do_reset();
    xpat = 11'd1100; ypat = 11'd1900;
    do_serve();
    for (int k = 1; k <= 105; k++) begin
      do_tick();
      check_model($sformatf("down%0d", k));
    end
    check("bot_y710", int'(yball), 710);
    check("bot_x720", int'(xball), 720);
    do_tick();
    check("bot_y712", int'(yball), 712);
    check("bot_x724", int'(xball), 724);
    do_tick();
    check("bot_y709", int'(yball), 709);
    do_serve();
    check("play_serve_x", int'(xball), 728);
    check("play_serve_y", int'(yball), 709);
    check("play_serve_state", int'(state), 1);

    // Asynchronous reset between frames.
    @(negedge clk) reset = 1'b1;
    #1;
    check("arst_x", int'(xball), 300);
    check("arst_y", int'(yball), 395);
    check("arst_score", int'(score), 0);
    check("arst_state", int'(state), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    model_reset();

    // Rally against a tracking paddle at x=1100.
    xpat = 11'd1100; ypat = 11'd395;
    do_serve();
    t = 0;
    while (m_score < 4 && t < 3000) begin
      ypat = 11'(m_y);
      do_tick();
      t++;
      check_model($sformatf("rally%0d", t));
      if (t == 179) check("pre_hit_x", int'(xball), 1016);
      if (t == 180) begin
        check("hit1_x", int'(xball), 1020);
        check("hit1_score", int'(score), 1);
      end
      if (t == 415) check("left_x80", int'(xball), 80);
      if (t == 416) check("left_x78", int'(xball), 78);
    end
    check("rally_timeout", t < 3000 ? 1 : 0, 1);
    check("hit4_score", int'(score), 4);
    check("hit4_x", int'(xball), 1020);
    ypat = 11'(m_y);
    do_tick();
    check("vx5_x", int'(xball), 1015);
    check_model("vx5");

    // Paddle out of reach -> miss, 60 frozen frames, serve ignored.
    ypat = 11'd1900;
    t = 0;
    while (m_mode != 2 && t < 1000) begin
      do_tick();
      t++;
      check_model($sformatf("tomiss%0d", t));
    end
    check("miss_state", int'(state), 2);
    check("miss_x", int'(xball), 1202);
    for (int k = 1; k <= 59; k++) begin
      if (k == 30) do_serve();
      do_tick();
      check_model($sformatf("frozen%0d", k));
    end
    check("frozen59_state", int'(state), 2);
    check("frozen59_x", int'(xball), 1202);
    do_tick();
    check("miss_end_state", int'(state), 0);
    check("miss_end_x", int'(xball), 300);
    check("miss_end_y", int'(yball), 395);
    check("miss_end_score", int'(score), 4);

    // Randomised rallies against the model.
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) do_reset();
      do_serve();
      check_model($sformatf("r%0d_serve", r));
      n = 0;
      while (m_mode != 0 && n < 600) begin
        xpat = 11'($urandom_range(1000, 1220));
        t = m_y + int'($urandom_range(0, 200)) - 100;
        if (t < 0) t = 0;
        ypat = 11'(t);
        if ($urandom_range(0, 19) == 0) begin
          do_serve();
          check_model($sformatf("r%0d_sv%0d", r, n));
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_tick();
        n++;
        check_model($sformatf("r%0d_t%0d", r, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
